// File: rtl/zeroriscy_fetch_req_ctrl.sv
// zeroriscy_fetch_req_ctrl: instruction-side fetch initiator (req/gnt/rvalid) feeding the fetch FIFO
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i, branch_i            core fetch enable, one-cycle redirect pulse
//   branch_addr_i              redirect target (bit0 ignored)
//   busy_o                     request pending or responses outstanding
//   instr_req_o/addr_o         word-aligned memory request
//   instr_gnt_i/rvalid_i/rdata_i  memory handshake and in-order response
//   fifo_clear_o               clear fetch FIFO (follows branch_i)
//   fifo_in_valid_o/addr_o/rdata_o  word pushed into fetch FIFO
//   fifo_in_ready_i            FIFO can take at least two more words
// Optional build macro ZERORISCY_FETCH_ERR_EN adds instr_err_i, fetch_err_o, fetch_err_addr_o:
//   an errored response is not pushed, latches a sticky error and blocks fetching until branch_i.
module zeroriscy_fetch_req_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_clear_o,
  output logic        fifo_in_valid_o,
  output logic [31:0] fifo_in_addr_o,
  output logic [31:0] fifo_in_rdata_o,
  input  logic        fifo_in_ready_i
`ifdef ZERORISCY_FETCH_ERR_EN
  ,
  input  logic        instr_err_i,
  output logic        fetch_err_o,
  output logic [31:0] fetch_err_addr_o
`endif
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_GNT = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic        started_q, started_d;
  logic        gnt, rsp_live, rsp_err, err_block, can_issue, issue;
  logic [31:0] br_addr, issue_addr;
  logic [2:0]  pend_cnt;
`ifdef ZERORISCY_FETCH_ERR_EN
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  assign rsp_err          = instr_err_i;
  assign err_block        = err_q & ~branch_i;
  assign fetch_err_o      = err_q;
  assign fetch_err_addr_o = err_addr_q;
  always_comb begin
    err_d      = branch_i ? 1'b0 : (rsp_live & instr_err_i) ? 1'b1 : err_q;
    err_addr_d = (rsp_live & instr_err_i) ? rsp_addr_q : err_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
`else
  assign rsp_err   = 1'b0;
  assign err_block = 1'b0;
`endif
  assign gnt             = instr_req_o & instr_gnt_i;
  assign br_addr         = branch_addr_i & ~32'd1;
  assign rsp_live        = instr_rvalid_i & (discard_q == 2'd0) & ~branch_i;
  assign instr_req_o     = (state_q == WAIT_GNT);
  assign instr_addr_o    = req_addr_q;
  assign busy_o          = instr_req_o | (outstanding_q != 2'd0);
  assign fifo_clear_o    = branch_i;
  assign fifo_in_valid_o = rsp_live & ~rsp_err;
  assign fifo_in_addr_o  = fifo_in_valid_o ? rsp_addr_q : '0;
  assign fifo_in_rdata_o = fifo_in_valid_o ? instr_rdata_i : '0;
  // A branch lets the redirected stream start in the same cycle, so it also counts as started.
  // A request is only (re)issued when the bus is free: from IDLE, or on the gnt that frees it.
  always_comb begin
    can_issue  = (started_q | branch_i) & req_i & fifo_in_ready_i & ~err_block &
                 (({1'b0, outstanding_q} + {2'b0, gnt}) < 3'(MAX_OUTSTANDING));
    issue      = can_issue & ((state_q == IDLE) | gnt);
    issue_addr = branch_i ? {br_addr[31:2], 2'b00} : {fetch_addr_q[31:2], 2'b00};
    // Responses still owed to the old stream, including an ungranted request that must complete.
    pend_cnt   = {1'b0, outstanding_q} + {2'b0, gnt} - {2'b0, instr_rvalid_i} +
                 {2'b0, (state_q == WAIT_GNT) & ~gnt};
    state_d       = issue ? WAIT_GNT : gnt ? IDLE : state_q;
    req_addr_d    = issue ? issue_addr : req_addr_q;
    fetch_addr_d  = issue ? issue_addr + 32'd4 : branch_i ? br_addr : fetch_addr_q;
    rsp_addr_d    = branch_i ? br_addr : rsp_live ? {rsp_addr_q[31:2], 2'b00} + 32'd4 : rsp_addr_q;
    outstanding_d = outstanding_q + {1'b0, gnt} - {1'b0, instr_rvalid_i};
    discard_d     = branch_i ? pend_cnt[1:0] :
                    (instr_rvalid_i & (discard_q != 2'd0)) ? discard_q - 2'd1 : discard_q;
    started_d     = started_q | branch_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      req_addr_q    <= '0;
      rsp_addr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      req_addr_q    <= req_addr_d;
      rsp_addr_q    <= rsp_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      started_q     <= started_d;
    end
  // A response with nothing outstanding means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (!rst_n) instr_rvalid_i |-> (outstanding_q != 2'd0));
endmodule

// File: tb/tb_zeroriscy_fetch_req_ctrl.sv
// tb_zeroriscy_fetch_req_ctrl: scoreboard bench for the fetch request controller
module tb_zeroriscy_fetch_req_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, req_i, branch_i, busy_o, instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic        fifo_clear_o, fifo_in_valid_o, fifo_in_ready_i;
  logic [31:0] branch_addr_i, instr_addr_o, instr_rdata_i, fifo_in_addr_o, fifo_in_rdata_o;
  logic        gnt_en, rsp_en, err_en;
  int          gnt_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_push[$];
  logic [31:0] pend[$];
`ifdef ZERORISCY_FETCH_ERR_EN
  logic        instr_err_i, fetch_err_o;
  logic [31:0] fetch_err_addr_o;
`endif
  zeroriscy_fetch_req_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fifo_clear_o(fifo_clear_o), .fifo_in_valid_o(fifo_in_valid_o),
    .fifo_in_addr_o(fifo_in_addr_o), .fifo_in_rdata_o(fifo_in_rdata_o),
    .fifo_in_ready_i(fifo_in_ready_i)
`ifdef ZERORISCY_FETCH_ERR_EN
    , .instr_err_i(instr_err_i), .fetch_err_o(fetch_err_o), .fetch_err_addr_o(fetch_err_addr_o)
`endif
  );
  always #5 clk = ~clk;
  assign instr_gnt_i = gnt_en & instr_req_o;
  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Memory: grants seen mid-cycle are queued at the edge; responses in order, one per cycle.
  initial begin
    logic g;
    logic [31:0] ga, a;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
`ifdef ZERORISCY_FETCH_ERR_EN
    instr_err_i = 1'b0;
`endif
    forever begin
      @(negedge clk);
      g  = instr_req_o & instr_gnt_i;
      ga = instr_addr_o;
      @(posedge clk);
      #1;
      if (g) begin
        pend.push_back(ga);
        gnt_cnt++;
      end
      if (rsp_en && pend.size() > 0) begin
        a = pend.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = dat(a);
`ifdef ZERORISCY_FETCH_ERR_EN
        instr_err_i = err_en;
`endif
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
`ifdef ZERORISCY_FETCH_ERR_EN
        instr_err_i = 1'b0;
`endif
      end
    end
  end
  // Monitor: compare every granted request address and every FIFO push against the queues.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (instr_req_o && instr_gnt_i) begin
        if (exp_req.size() == 0) chk("unexpected_req", instr_addr_o, 32'hxxxx_xxxx);
        else chk("req_addr", instr_addr_o, exp_req.pop_front());
      end
      if (fifo_in_valid_o) begin
        if (exp_push.size() == 0) chk("unexpected_push", fifo_in_addr_o, 32'hxxxx_xxxx);
        else begin
          logic [63:0] e;
          e = exp_push.pop_front();
          chk("push_addr", fifo_in_addr_o, e[63:32]);
          chk("push_data", fifo_in_rdata_o, e[31:0]);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic fetch(input logic [31:0] a, input int n);
    int base;
    base = gnt_cnt + int'(instr_req_o);
    branch_i = 1'b1;
    branch_addr_i = a;
    req_i = 1'b1;
    #1;
    chk("fifo_clear", {31'b0, fifo_clear_o}, 32'd1);
    cyc();
    branch_i = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gnt_cnt + int'(instr_req_o) >= base + n) break;
    end
    req_i = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    chk("drain_idle", {31'b0, busy_o}, 32'd0);
  endtask
  task automatic exp_w(input logic [31:0] push_addr, input logic [31:0] mem_addr);
    exp_push.push_back({push_addr, dat(mem_addr)});
  endtask
  initial begin
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    fifo_in_ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; err_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, instr_req_o}, 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_clear", {31'b0, fifo_clear_o}, 32'd0);
    chk("rst_valid", {31'b0, fifo_in_valid_o}, 32'd0);
    chk("rst_faddr", fifo_in_addr_o, 32'd0);
    cyc();
    rst_n = 1'b1;
    req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("no_req_before_branch", {31'b0, instr_req_o}, 32'd0);
    end
    req_i = 1'b0;
    cyc();
    // boot
    exp_req.push_back(32'h80); exp_req.push_back(32'h84);
    exp_w(32'h80, 32'h80); exp_w(32'h84, 32'h84);
    fetch(32'h80, 2);
    drain();
    // unaligned target
    cyc();
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    exp_w(32'h102, 32'h100); exp_w(32'h104, 32'h104);
    fetch(32'h102, 2);
    drain();
    // stale responses dropped after a redirect
    cyc();
    rsp_en = 1'b0;
    exp_req.push_back(32'h200); exp_req.push_back(32'h204); exp_req.push_back(32'h400);
    exp_w(32'h400, 32'h400);
    fetch(32'h200, 2);
    for (int k = 0; k < 20 && instr_req_o; k++) @(negedge clk);
    chk("stale_two_out", {31'b0, busy_o}, 32'd1);
    cyc();
    rsp_en = 1'b1;
    fetch(32'h400, 1);
    drain();
    // backpressure with one outstanding
    cyc();
    exp_req.push_back(32'h700); exp_req.push_back(32'h704);
    exp_w(32'h700, 32'h700); exp_w(32'h704, 32'h704);
    branch_i = 1'b1; branch_addr_i = 32'h700; req_i = 1'b1;
    cyc();
    branch_i = 1'b0; fifo_in_ready_i = 1'b0;
    cyc();
    #1;
    chk("bp_noreq", {31'b0, instr_req_o}, 32'd0);
    chk("bp_push", {31'b0, fifo_in_valid_o}, 32'd1);
    cyc();
    #1;
    chk("bp_noreq2", {31'b0, instr_req_o}, 32'd0);
    fifo_in_ready_i = 1'b1;
    cyc();
    #1;
    chk("bp_resume", {31'b0, instr_req_o}, 32'd1);
    chk("bp_resume_addr", instr_addr_o, 32'h704);
    req_i = 1'b0;
    drain();
    // gnt stall with a branch on top
    cyc();
    exp_req.push_back(32'h300); exp_req.push_back(32'h500);
    exp_w(32'h500, 32'h500);
    gnt_en = 1'b0;
    branch_i = 1'b1; branch_addr_i = 32'h300; req_i = 1'b1;
    cyc();
    branch_addr_i = 32'h500;
    #1;
    chk("stall_clear", {31'b0, fifo_clear_o}, 32'd1);
    chk("stall_req", {31'b0, instr_req_o}, 32'd1);
    chk("stall_addr", instr_addr_o, 32'h300);
    cyc();
    branch_i = 1'b0;
    #1;
    chk("stall_hold", instr_addr_o, 32'h300);
    gnt_en = 1'b1;
    cyc();
    #1;
    chk("stall_new_addr", instr_addr_o, 32'h500);
    req_i = 1'b0;
    drain();
    // address wrap
    cyc();
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_w(32'hFFFF_FFFC, 32'hFFFF_FFFC); exp_w(32'h0, 32'h0);
    fetch(32'hFFFF_FFFC, 2);
    drain();
`ifdef ZERORISCY_FETCH_ERR_EN
    cyc();
    exp_req.push_back(32'h600); exp_req.push_back(32'h800);
    exp_w(32'h800, 32'h800);
    err_en = 1'b1;
    fetch(32'h600, 1);
    drain();
    err_en = 1'b0;
    chk("err_flag", {31'b0, fetch_err_o}, 32'd1);
    chk("err_addr", fetch_err_addr_o, 32'h600);
    req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("err_noreq", {31'b0, instr_req_o}, 32'd0);
    end
    fetch(32'h800, 1);
    drain();
    chk("err_cleared", {31'b0, fetch_err_o}, 32'd0);
`endif
    repeat (3) cyc();
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("push_queue_empty", exp_push.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
